// File: rtl/fifo_mode_ctrl.sv
// Purpose: FILL/PROC/DRAIN sequencer for the convertible packet FIFO; owns memory addressing, write enable and mux select.
// Latency: write is same-cycle as the accepted word; out_wr follows the issued read by 1 cycle (cpu_done to first out_wr = 2).
// Backpressure: in_rdy is high only in FILL; out_rdy=0 stalls read issue in DRAIN; PROC waits indefinitely for cpu_done.
module fifo_mode_ctrl #(
  parameter int ADDR_W = 9,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_wr,
  output logic              in_rdy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mux_sel,
  output logic              cpu_mode,
  input  logic              cpu_done,
  output logic [ADDR_W-1:0] pkt_tail,
  input  logic              out_rdy,
  output logic              out_wr,
  output logic              pkt_ovf
);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_PROC  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] raddr_hold;
  logic              in_body;
  logic              drain_last;

  logic              accept;
  logic              eop;
  logic              full;
  logic              rd_issue;

  // in_rdy is only ever high in FILL, so it alone qualifies an accepted word.
  assign accept    = in_wr & in_rdy;
  // Gate with reset so an in_wr held during reset can never reach the memory.
  assign mem_we    = accept & ~reset;
  assign mem_waddr = wptr;

  // A non-zero ctrl byte only ends the packet once a body word has been seen;
  // before that it is a header word.
  assign eop  = accept & in_body & (in_ctrl != '0);
  // Last address reached without an EOP: this word is kept and the packet is truncated.
  assign full = accept & ~eop & (wptr == LAST_ADDR);

  // Reads are issued combinationally so the memory's 1-cycle latency lines up with
  // the registered out_wr; between issues the last address is held.
  assign rd_issue  = (state == ST_DRAIN) & out_rdy & ~drain_last;
  assign mem_raddr = rd_issue ? rptr : raddr_hold;

  assign mux_sel  = (state == ST_PROC);
  assign cpu_mode = (state == ST_PROC);

  // Mode sequencing, pointers, packet tail and the registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      in_rdy     <= 1'b1;
      wptr       <= '0;
      rptr       <= '0;
      raddr_hold <= '0;
      pkt_tail   <= '0;
      in_body    <= 1'b0;
      drain_last <= 1'b0;
      out_wr     <= 1'b0;
      pkt_ovf    <= 1'b0;
    end else begin
      pkt_ovf <= 1'b0;
      out_wr  <= rd_issue;
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (eop || full) begin
              pkt_tail <= wptr;
              in_rdy   <= 1'b0;
              in_body  <= 1'b0;
              wptr     <= '0;
              pkt_ovf  <= full;
              state    <= ST_PROC;
            end else begin
              wptr <= wptr + 1'b1;
              if (in_ctrl == '0) begin
                in_body <= 1'b1;
              end
            end
          end
        end
        ST_PROC: begin
          if (cpu_done) begin
            rptr       <= '0;
            drain_last <= 1'b0;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The cycle after the tail read carries the final out_wr; hand back to FILL then.
          if (drain_last) begin
            drain_last <= 1'b0;
            raddr_hold <= '0;
            in_rdy     <= 1'b1;
            state      <= ST_FILL;
          end else if (rd_issue) begin
            raddr_hold <= rptr;
            rptr       <= rptr + 1'b1;
            if (rptr == pkt_tail) begin
              drain_last <= 1'b1;
            end
          end
        end
        default: begin
          in_rdy  <= 1'b1;
          in_body <= 1'b0;
          wptr    <= '0;
          state   <= ST_FILL;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Input acceptance, CPU ownership and output strobes never overlap.
  a_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({in_rdy, cpu_mode, out_wr}));
  // The memory is only written while filling.
  a_we_fill: assert property (@(posedge clk) disable iff (reset)
    mem_we |-> (state == ST_FILL));
`endif

endmodule

// File: tb/tb_fifo_mode_ctrl.sv
// Purpose: randomized and directed bench for fifo_mode_ctrl against a packet-level reference model and a memory model.
// Latency: inputs driven 1 time unit after posedge, outputs compared at the following negedge.
// Backpressure: out_rdy randomized/toggled; in_wr and cpu_done also driven in modes where they must be ignored.
module tb_fifo_mode_ctrl;

  localparam int ADDR_W = 9;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              in_wr = 1'b0;
  logic              in_rdy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mux_sel;
  logic              cpu_mode;
  logic              cpu_done = 1'b0;
  logic [ADDR_W-1:0] pkt_tail;
  logic              out_rdy = 1'b0;
  logic              out_wr;
  logic              pkt_ovf;

  logic [15:0] in_data = '0;
  logic [15:0] mem [DEPTH];
  logic [15:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet-level view of the sequencer.
  bit          m_fill, m_proc, m_drain, m_body, m_outwr, m_ovf;
  logic [15:0] m_words[$];
  int          m_tail, m_issued, m_outcnt;

  fifo_mode_ctrl #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mux_sel   (mux_sel),
    .cpu_mode  (cpu_mode),
    .cpu_done  (cpu_done),
    .pkt_tail  (pkt_tail),
    .out_rdy   (out_rdy),
    .out_wr    (out_wr),
    .pkt_ovf   (pkt_ovf)
  );

  always #5 clk = ~clk;

  // Packet memory with a 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
    rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 1'b1; m_proc = 1'b0; m_drain = 1'b0; m_body = 1'b0;
    m_outwr = 1'b0; m_ovf = 1'b0;
    m_words.delete();
    m_tail = 0; m_issued = 0; m_outcnt = 0;
  endtask

  task automatic end_pkt(input bit ovf);
    m_tail = m_words.size() - 1;
    m_fill = 1'b0;
    m_proc = 1'b1;
    m_body = 1'b0;
    m_ovf  = ovf;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_rdy"},    in_rdy,    1);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_raddr"}, mem_raddr, 0);
    chk({tag, "_mux_sel"},   mux_sel,   0);
    chk({tag, "_cpu_mode"},  cpu_mode,  0);
    chk({tag, "_pkt_tail"},  pkt_tail,  0);
    chk({tag, "_out_wr"},    out_wr,    0);
    chk({tag, "_pkt_ovf"},   pkt_ovf,   0);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit wr, input logic [CTRL_W-1:0] ctrl, input bit done, input bit ordy);
    bit issue;
    @(posedge clk);
    #1;
    in_wr = wr; in_ctrl = ctrl; cpu_done = done; out_rdy = ordy;
    in_data = 16'($urandom);
    @(negedge clk);
    issue = m_drain && ordy && (m_issued <= m_tail);
    chk("in_rdy", in_rdy, m_fill);
    chk("mem_we", mem_we, m_fill && wr);
    if (m_fill && wr) chk("mem_waddr", mem_waddr, m_words.size());
    chk("mux_sel", mux_sel, m_proc);
    chk("cpu_mode", cpu_mode, m_proc);
    chk("out_wr", out_wr, m_outwr);
    if (m_outwr && m_outcnt < m_words.size()) begin
      chk("out_data", rdata, m_words[m_outcnt]);
      m_outcnt++;
    end
    chk("pkt_ovf", pkt_ovf, m_ovf);
    chk("pkt_tail", pkt_tail, m_tail);
    if (issue) chk("mem_raddr", mem_raddr, m_issued);
    else if (!m_drain) chk("mem_raddr_idle", mem_raddr, 0);

    m_ovf   = 1'b0;
    m_outwr = issue;
    if (m_fill) begin
      if (wr) begin
        m_words.push_back(in_data);
        if (ctrl != 0 && m_body) end_pkt(1'b0);
        else if (m_words.size() == DEPTH) end_pkt(1'b1);
        else if (ctrl == 0) m_body = 1'b1;
      end
    end else if (m_proc) begin
      if (done) begin
        m_proc = 1'b0; m_drain = 1'b1; m_issued = 0; m_outcnt = 0;
      end
    end else begin
      if (m_issued > m_tail) begin
        m_drain = 1'b0; m_fill = 1'b1;
        m_words.delete();
      end else if (issue) begin
        m_issued++;
      end
    end
  endtask

  task automatic idle_inputs();
    in_wr = 1'b0; in_ctrl = '0; cpu_done = 1'b0; out_rdy = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle, with in_wr held high to probe write gating.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #1;
    in_wr = 1'b1; out_rdy = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    #1 reset = 1'b1;
    in_wr = 1'b1;
    #2;
    check_reset_vals("rst");
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    // Header, three body words, EOP; in_wr and out_rdy held during PROC; drain.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // cpu_done while filling is ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Short packet drained with out_rdy toggling.
    step(1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0, 1'(i % 2));

    // Full-depth packet without EOP truncates at the last address.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // EOP landing exactly on the last address is a normal EOP.
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic: sparse EOPs, random CPU completion and downstream stalls.
    for (int i = 0; i < 8000; i++) begin
      logic [CTRL_W-1:0] c;
      c = ($urandom_range(0, 3) == 0) ? CTRL_W'($urandom_range(1, 255)) : '0;
      step(1'($urandom_range(0, 99) < 70), c,
           1'($urandom_range(0, 99) < 10),
           1'($urandom_range(0, 99) < 60));
    end

    // Let any in-flight packet reach FILL, then build one and reset mid-drain.
    for (int i = 0; i < 2 * DEPTH + 8 && !m_fill; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("reach_fill", m_fill, 1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pre_rst_drain", m_drain, 1);
    mid_reset("mid_rst");

    // After release a new packet starts at address 0.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h08, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
